// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
// Operation codes follow funct3[1:0] of DIV/DIVU/REM/REMU.
package div_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } div_state_e;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;
  localparam logic [XLEN-1:0] SIGNED_OVF_Q  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] mag(
    input logic [XLEN-1:0] v,
    input logic            neg
  );
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/divide_unit_iter.sv
// One restoring-division step: shift {rem,quo} left, trial subtract.
// The trial is one bit wider because the shifted remainder can exceed XLEN bits.
module div_iter #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] shifted;
  logic [W:0] trial;

  assign shifted = {rem, quo[W-1]};
  assign trial   = shifted - {1'b0, divisor};

  always_comb begin
    rem_next = shifted[W-1:0];
    quo_next = {quo[W-2:0], 1'b0};
    if (!trial[W]) begin
      rem_next = trial[W-1:0];
      quo_next = {quo[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/divide_unit.sv
// EXE-stage radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Raises divide_stall while working and holds its result until EXE->MEM advances.
module divide_unit
  import div_pkg::*;
#(
  parameter int XLEN = div_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            div_start,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  input  logic            exe_mem_reg_en,
  output logic            divide_stall,
  output logic            div_done,
  output logic [XLEN-1:0] div_result
);

  localparam int CNT_W = $clog2(XLEN);

  div_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [1:0]      op_q;
  logic            neg_quo;
  logic            neg_rem;

  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic            div_zero;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  assign is_signed = ~div_op[0];
  assign a_neg     = is_signed & rs1_data[XLEN-1];
  assign b_neg     = is_signed & rs2_data[XLEN-1];
  assign div_zero  = (rs2_data == '0);
  assign ovf       = is_signed & (rs1_data == SIGNED_OVF_Q)
                   & (rs2_data == '1);
  assign special   = div_zero | ovf;

  div_iter #(.W(XLEN)) u_iter (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      op_q    <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (div_start) begin
            op_q  <= div_op;
            dvs_q <= mag(rs2_data, b_neg);
            if (special) begin
              state   <= S_DONE;
              quo_q   <= div_zero ? DIV_BY_ZERO_Q : SIGNED_OVF_Q;
              rem_q   <= div_zero ? rs1_data : '0;
              neg_quo <= 1'b0;
              neg_rem <= 1'b0;
            end else begin
              state   <= S_BUSY;
              cnt     <= CNT_W'(XLEN - 1);
              quo_q   <= mag(rs1_data, a_neg);
              rem_q   <= '0;
              neg_quo <= a_neg ^ b_neg;
              neg_rem <= a_neg;
            end
          end
        end
        S_BUSY: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          if (cnt == '0) state <= S_DONE;
          else           cnt   <= cnt - 1'b1;
        end
        S_DONE: begin
          if (exe_mem_reg_en) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    divide_stall = 1'b0;
    div_done     = 1'b0;
    if (!flush) begin
      unique case (1'b1)
        (state == S_IDLE): divide_stall = div_start;
        (state == S_BUSY): divide_stall = 1'b1;
        (state == S_DONE): div_done     = 1'b1;
        default: ;
      endcase
    end
  end

  assign quo_fix    = neg_quo ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix    = neg_rem ? (~rem_q + 1'b1) : rem_q;
  assign div_result = op_q[1] ? rem_fix : quo_fix;

endmodule

// File: tb/tb_divide_unit.sv
// Directed self-checking bench for divide_unit.
// Covers latency, sign rules, special cases, flush, hold and back-to-back.
module tb_divide_unit;

  logic        clk;
  logic        reset;
  logic        div_start;
  logic [1:0]  div_op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        exe_mem_reg_en;
  logic        divide_stall;
  logic        div_done;
  logic [31:0] div_result;

  int n_cmp;
  int n_bad;

  divide_unit dut (
    .clk            (clk),
    .reset          (reset),
    .div_start      (div_start),
    .div_op         (div_op),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .flush          (flush),
    .exe_mem_reg_en (exe_mem_reg_en),
    .divide_stall   (divide_stall),
    .div_done       (div_done),
    .div_result     (div_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns one cycle after retiring, at negedge+1.
  task automatic run(string tag, logic [1:0] op, logic [31:0] a,
                     logic [31:0] b, logic [31:0] exp, int exp_st,
                     int hold);
    int st;
    bit seen;
    st   = 0;
    seen = 0;
    div_start      = 1'b1;
    div_op         = op;
    rs1_data       = a;
    rs2_data       = b;
    exe_mem_reg_en = 1'b0;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (div_done) begin
        seen = 1;
        break;
      end
      if (divide_stall) st++;
      @(negedge clk);
      rs1_data = $urandom;
      rs2_data = $urandom;
      div_op   = 2'($urandom);
    end
    chk({tag, ":done"}, 32'(seen), 32'd1);
    chk({tag, ":stall"}, 32'(st), 32'(exp_st));
    chk({tag, ":res"}, div_result, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      chk({tag, ":hold_res"}, div_result, exp);
      chk({tag, ":hold_done"}, 32'(div_done), 32'd1);
      chk({tag, ":hold_stall"}, 32'(divide_stall), 32'd0);
    end
    exe_mem_reg_en = 1'b1;
    @(negedge clk);
    exe_mem_reg_en = 1'b0;
    div_start      = 1'b0;
    #1;
    chk({tag, ":idle_done"}, 32'(div_done), 32'd0);
    chk({tag, ":idle_stall"}, 32'(divide_stall), 32'd0);
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    reset          = 1'b1;
    div_start      = 1'b0;
    div_op         = 2'b00;
    rs1_data       = '0;
    rs2_data       = '0;
    flush          = 1'b0;
    exe_mem_reg_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(divide_stall), 32'd0);
    chk("rst_done", 32'(div_done), 32'd0);
    chk("rst_res", div_result, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33, 0);
    run("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33, 0);
    run("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
    run("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);
    run("div_min_2", 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 33, 0);
    run("divu_big", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33, 0);
    run("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 33, 0);
    run("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run("rem_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 1, 0);
    run("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

    // Kill a DIV at BUSY iteration 10, then a fresh divide runs in full.
    div_start = 1'b1;
    div_op    = 2'b00;
    rs1_data  = 32'd1000;
    rs2_data  = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_stall", 32'(divide_stall), 32'd0);
    chk("flush_done", 32'(div_done), 32'd0);
    @(negedge clk);
    flush     = 1'b0;
    div_start = 1'b0;
    #1;
    chk("post_flush_stall", 32'(divide_stall), 32'd0);
    chk("post_flush_done", 32'(div_done), 32'd0);
    run("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 33, 0);

    run("hold_div", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 4);

    run("b2b_20_4", 2'b01, 32'd20, 32'd4, 32'd5, 33, 0);
    run("b2b_21_4", 2'b01, 32'd21, 32'd4, 32'd5, 33, 0);

    // Reset in the middle of an iteration sequence.
    div_start = 1'b1;
    div_op    = 2'b01;
    rs1_data  = 32'd100;
    rs2_data  = 32'd7;
    repeat (5) @(negedge clk);
    reset     = 1'b1;
    div_start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(divide_stall), 32'd0);
    chk("mid_rst_done", 32'(div_done), 32'd0);
    chk("mid_rst_res", div_result, 32'd0);
    @(negedge clk);
    run("after_rst", 2'b11, 32'd23, 32'd5, 32'd3, 33, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/divide_unit.md
Name: divide_unit

Overview:
Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It lives in the EXE stage. It is the producer of divide_stall, which the pipeline controller consumes to freeze the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. It consumes the controller's EXE/MEM enable as its release handshake, so a finished result is held until the pipeline actually advances.

Parameters:
XLEN, 32, operand/result width
CNT_W, $clog2(XLEN), iteration counter width (derived, not overridden)

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
div_start  input  1  EXE holds a valid divide instruction this cycle
div_op  input  2  div_op_e: DIV=00, DIVU=01, REM=10, REMU=11 (funct3[1:0])
rs1_data  input  XLEN  dividend
rs2_data  input  XLEN  divisor
flush  input  1  EXE instruction killed (branch_hazard | mret_type | interrupt)
exe_mem_reg_en  input  1  pipeline advances EXE->MEM this cycle
divide_stall  output  1  hold pipeline; to pipeline controller
div_done  output  1  div_result valid for the instruction in EXE
div_result  output  XLEN  quotient or remainder, per div_op

Behaviour:
- Reset: state=IDLE, counter=0, all datapath registers=0. divide_stall=0, div_done=0, div_result=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If div_start & ~flush: capture |rs1|, |rs2| (signed ops only), op, sign flags. divide_stall=1 combinationally in this cycle.
  - Next state is DONE if the op is a special case, otherwise BUSY with counter=XLEN-1.
- BUSY:
  - One restoring iteration per cycle: shift {rem,quo} left by 1; trial = rem - divisor; if non-negative, rem=trial and quo[0]=1.
  - divide_stall=1. When counter==0, go to DONE; otherwise decrement counter.
- DONE:
  - divide_stall=0, div_done=1.
  - div_result is combinational from the final registers: quotient for DIV/DIVU, remainder for REM/REMU.
  - Stay in DONE while ~exe_mem_reg_en, so the result stays stable under other stalls. Go to IDLE when exe_mem_reg_en=1.
  - div_start is ignored in DONE, so the same instruction is never restarted.
- Latency:
  - Normal op accepted at cycle T: divide_stall=1 for cycles T..T+32 (33 cycles); div_done=1 from T+33.
  - Special case accepted at T: divide_stall=1 for T only; div_done=1 at T+1.
- Sign rules (signed ops): quotient is negated when the operand signs differ; remainder takes the sign of the dividend. |0x8000_0000| is treated as an unsigned magnitude of 2^31.
- Special cases (no iteration):
  - Divisor 0: quotient=all ones, remainder=rs1.
  - DIV/REM with rs1=0x8000_0000 and rs2=0xFFFF_FFFF: quotient=0x8000_0000, remainder=0.
- flush in any state:
  - Next state=IDLE.
  - divide_stall and div_done are forced to 0 that same cycle.
  - A div_start in the same cycle is not accepted.
- Back-to-back divides: the second is accepted the cycle after the DONE->IDLE transition, when it sits in EXE.
- div_op/rs1/rs2 changing after acceptance has no effect.
- reset asserted mid-BUSY returns to the reset state on the next edge.

Decomposition:
- Package div_pkg: div_op_e enum, div_state_e enum, XLEN default, special-case constants (DIV_BY_ZERO_Q, SIGNED_OVF_Q).
- Sub-module div_iter: the combinational single-step restoring datapath ({rem,quo},divisor -> next {rem,quo}). The FSM, counter and sign fix-up stay in divide_unit.

Test Plan:
- DIVU rs1=100, rs2=7 -> divide_stall high 33 cycles; then div_done=1, div_result=14. Repeat as REMU -> 2.
- DIV rs1=-7 (0xFFFF_FFF9), rs2=2 -> 0xFFFF_FFFD (-3). REM with the same operands -> 0xFFFF_FFFF (-1).
- DIVU 5/0 -> stall for 1 cycle only, result 0xFFFF_FFFF. REM 5/0 -> 5. DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000 after 1 stall cycle. REM with the same operands -> 0.
- Start DIV, then pulse flush at BUSY iteration 10 -> divide_stall=0 that cycle, state IDLE next cycle. A fresh DIVU 9/3 then yields 3 with full 33-cycle latency.
- Reach DONE with exe_mem_reg_en=0 for 4 cycles -> div_done and div_result stay stable, divide_stall=0. Raise exe_mem_reg_en -> IDLE next cycle.
- Two consecutive DIVU (20/4, then 21/4) -> results 5 then 5. The second starts only after the first retires, with no double acceptance.
